// File: rtl/ext_pkg.sv
// Shared definitions for the immediate extender and its two-requester arbiter.
package ext_pkg;

    localparam int unsigned IMM_W     = 16;
    localparam int unsigned EXT_W     = 32;
    localparam int unsigned EOP_W     = 2;
    localparam int unsigned NREQ      = 2;
    localparam int unsigned REQ_IDX_W = 1;

    localparam logic [EOP_W-1:0] EOP_SEXT     = 2'b00;
    localparam logic [EOP_W-1:0] EOP_ZEXT     = 2'b01;
    localparam logic [EOP_W-1:0] EOP_LUI      = 2'b10;
    localparam logic [EOP_W-1:0] EOP_SEXT_SL2 = 2'b11;

endpackage

// File: rtl/ext.sv
// Combinational immediate extender: sign/zero extend, upper-load, or sign-extend shifted by 2.
module ext
    import ext_pkg::*;
(
    input  logic [IMM_W-1:0] imm,
    input  logic [EOP_W-1:0] EOp,
    output logic [EXT_W-1:0] ext
);

    localparam int unsigned PAD_W = EXT_W - IMM_W;

    always_comb begin
        ext = '0;
        case (EOp)
            EOP_SEXT:     ext = {{PAD_W{imm[IMM_W-1]}}, imm};
            EOP_ZEXT:     ext = {{PAD_W{1'b0}}, imm};
            EOP_LUI:      ext = {imm, {PAD_W{1'b0}}};
            // top two bits of the shifted sign extension fall off the word
            EOP_SEXT_SL2: ext = {{(PAD_W-2){imm[IMM_W-1]}}, imm, 2'b00};
            default:      ext = '0;
        endcase
    end

endmodule

// File: rtl/ext_arbiter.sv
// Round-robin sharing of one immediate extender between two valid/ready requesters,
// with a single registered valid/ready output stage.
module ext_arbiter
    import ext_pkg::*;
#(
    parameter bit RR_INIT = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [IMM_W-1:0]     req_imm0,
    input  logic [IMM_W-1:0]     req_imm1,
    input  logic [EOP_W-1:0]     req_eop0,
    input  logic [EOP_W-1:0]     req_eop1,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [EXT_W-1:0]     out_ext,
    output logic [REQ_IDX_W-1:0] out_src
);

    logic                 ptr_q, ptr_d;
    logic                 out_valid_q, out_valid_d;
    logic [EXT_W-1:0]     out_ext_q, out_ext_d;
    logic [REQ_IDX_W-1:0] out_src_q, out_src_d;

    logic                 can_accept_c;
    logic [NREQ-1:0]      gnt_c;
    logic                 accept_c;
    logic                 sel_c;
    logic [IMM_W-1:0]     imm_c;
    logic [EOP_W-1:0]     eop_c;
    logic [EXT_W-1:0]     ext_c;

    // Grant: pointer holder wins a tie; a lone requester wins regardless of pointer.
    // rst_n gating keeps both grants low for the whole reset assertion.
    always_comb begin
        can_accept_c = !out_valid_q || out_ready;
        gnt_c        = '0;
        if (rst_n && can_accept_c) begin
            gnt_c[0] = req_valid[0] && (!ptr_q || !req_valid[1]);
            gnt_c[1] = req_valid[1] && ( ptr_q || !req_valid[0]);
        end
    end

    assign accept_c  = |gnt_c;
    assign sel_c     = gnt_c[1];
    assign imm_c     = sel_c ? req_imm1 : req_imm0;
    assign eop_c     = sel_c ? req_eop1 : req_eop0;
    assign req_ready = gnt_c;

    ext u_ext (
        .imm (imm_c),
        .EOp (eop_c),
        .ext (ext_c)
    );

    // Output stage: load on accept (covers drain+reload in one cycle), else drain.
    always_comb begin
        ptr_d       = ptr_q;
        out_valid_d = out_valid_q;
        out_ext_d   = out_ext_q;
        out_src_d   = out_src_q;
        if (accept_c) begin
            out_valid_d = 1'b1;
            out_ext_d   = ext_c;
            out_src_d   = REQ_IDX_W'(sel_c);
            ptr_d       = !sel_c;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q       <= RR_INIT;
            out_valid_q <= 1'b0;
            out_ext_q   <= '0;
            out_src_q   <= '0;
        end else begin
            ptr_q       <= ptr_d;
            out_valid_q <= out_valid_d;
            out_ext_q   <= out_ext_d;
            out_src_q   <= out_src_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_ext   = out_ext_q;
    assign out_src   = out_src_q;

endmodule

// File: doc/ext_arbiter.md
# ext_arbiter

Shares one immediate extender (16-bit immediate, 2-bit mode, 32-bit result) between two requesters. Arbitration is round-robin, and each requester uses a valid/ready handshake. The extended result is held in a single output register with its own valid/ready handshake. The block sits between the decode-side requesters (for example the ALU-operand path and the branch-offset path) and any consumer that may stall.

## Interface
Parameters:
- `RR_INIT`, default 0: the requester that has priority after reset (0 or 1).

Ports:
- `clk` input 1: rising-edge clock.
- `rst_n` input 1: reset. Asynchronous assert, active-low.
- `req_valid` input 2: bit i is high when requester i has a request.
- `req_ready` output 2: bit i is high when requester i's request is accepted this cycle.
- `req_imm0`, `req_imm1` input 16: immediate for requester 0 and 1.
- `req_eop0`, `req_eop1` input 2: extension mode for requester 0 and 1.
- `out_valid` output 1: the output register holds a result.
- `out_ready` input 1: the consumer takes the result this cycle.
- `out_ext` output 32: extended result.
- `out_src` output 1: index of the requester that produced `out_ext`.

## Operation
- EOp encoding:
  - 00: sign-extend.
  - 01: zero-extend.
  - 10: `{imm,16'h0}`.
  - 11: sign-extend, then shift left by 2. Bits [31:30] of the shifted value are discarded.
- `can_accept = !out_valid || out_ready`.
- Grant rule:
  - `req_ready[i] = can_accept && req_valid[i] && (ptr==i || !req_valid[1-i])`.
  - At most one bit of `req_ready` is high in any cycle.
- An accept (handshake) on requester i happens when `req_valid[i] && req_ready[i]`. On the next clock edge:
  - `out_ext` is loaded with the extension of `req_immi` using `req_eopi`.
  - `out_src` is set to i.
  - `out_valid` is set to 1.
  - `ptr` is set to 1-i.
- With no accept, `ptr` holds.
- With no accept and `out_ready` high, `out_valid` is cleared.
- While `out_valid && !out_ready`:
  - `out_ext` and `out_src` hold stable.
  - Both bits of `req_ready` are 0.
- Fairness: if a requester holds `req_valid`, it is accepted within 2 consecutive accepts.
- Requesters must hold their immediate and mode stable while valid is high and ready is low. The arbiter does not latch them before an accept.
- Reset (asynchronous, may occur mid-transfer):
  - `out_valid`=0, `out_ext`=0, `out_src`=0, `ptr`=`RR_INIT`.
  - Any un-consumed result is discarded.
  - `req_ready` is 0 while `rst_n`=0.

## Timing
- Latency: accept on edge N gives `out_valid` high from edge N+1.
- Throughput: 1 result per cycle when `out_ready` is held high.
- Simultaneous accept and drain in the same cycle is legal. The register reloads with no bubble.
- `req_ready` depends combinationally on `req_valid` (both bits), `out_valid` and `out_ready`.
- `out_valid`, `out_ext` and `out_src` are registered outputs with no combinational input-to-output path.
- Both requesters valid with `out_ready` held low: no accept, and `ptr` is unchanged until the stall clears.

## Structure
- Shared package (`ext_pkg`):
  - EOp localparams: `EOP_SEXT`=2'b00, `EOP_ZEXT`=2'b01, `EOP_LUI`=2'b10, `EOP_SEXT_SL2`=2'b11.
  - Requester index width.
- One sub-module: the existing `ext` extender (ports `imm`, `EOp`, `ext`), instantiated once.
  - It is fed by a 2:1 mux on the granted requester's immediate and mode.
- Arbiter logic consists of the `ptr` flop, the grant equations and the output register, all in `ext_arbiter`.

## Test plan
- Mode sweep: requester 0 only, `req_imm0`=16'h8F5A, `out_ready`=1.
  - EOp 00 gives 32'hFFFF8F5A.
  - EOp 01 gives 32'h00008F5A.
  - EOp 10 gives 32'h8F5A0000.
  - EOp 11 gives 32'hFFFE3D68.
  - Each result appears one cycle after its accept.
  - Same sweep with 16'h0F5A: EOp 11 gives 32'h00003D68, EOp 00 gives 32'h00000F5A.
- Round-robin: both requesters valid continuously, `RR_INIT`=0, `out_ready`=1.
  - `out_src` sequence is 0,1,0,1.
  - One result per cycle.
- Backpressure: accept on requester 1, then `out_ready`=0 for 3 cycles.
  - `out_ext`/`out_src` stay stable.
  - `req_ready`=2'b00.
  - When `out_ready` rises, that cycle both drains the result and accepts the next request.
- Single requester with idle partner: only `req_valid[1]`=1 with `ptr`=0.
  - Requester 1 is granted immediately.
  - `ptr` becomes 0 afterward.
- Reset mid-operation: drop `rst_n` while `out_valid`=1 and `out_ready`=0.
  - `out_valid`, `out_ext` and `out_src` go to 0 without waiting for a clock edge.
  - After release, the first grant with both requesters valid goes to `RR_INIT`.
